commutation_seq: RTL and testbench
==================================

Name: commutation_seq

Overview:
- Six-step commutation sequencer for one 3-phase H-bridge.
- Drives the 6-bit per-switch enable vector consumed by signal_gen.
- Runs an open-loop speed ramp from a start step period down to a target step period.
- Inserts dead-time (all switches off) between steps and provides a low-side brake mode.

Parameters:
- CNT_W, 16: width of the period counter and period inputs.
- DEAD_CYCLES, 4: all-off cycles inserted before every new drive pattern (>=1).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- enable_i  input  1  run request, level
- brake_i  input  1  brake request, level; priority over enable_i
- dir_i  input  1  1 = forward (step+1), 0 = reverse (step-1); sampled at step advance only
- start_period_i  input  CNT_W  initial drive-phase length in clk cycles
- period_i  input  CNT_W  target drive-phase length in clk cycles
- ramp_step_i  input  CNT_W  period decrement applied per step while ramping
- status_o  output  6  switch enables {HA,LA,HB,LB,HC,LC} to signal_gen
- step_o  output  3  current commutation step, 0..5
- step_pulse_o  output  1  one-cycle strobe on the last drive cycle of each step
- running_o  output  1  high in DRIVE and DEAD, and during the post-brake dead phase
- locked_o  output  1  current period equals target

Behaviour:
- Clock and reset: single clock clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: status_o=0, step_o=0, step_pulse_o=0, running_o=0, locked_o=0, FSM=IDLE, internal counter=0, cur_period=0.
- Step patterns (status_o):
  - step 0 = 100100 (HA,LB)
  - step 1 = 100001 (HA,LC)
  - step 2 = 001001 (HB,LC)
  - step 3 = 011000 (HB,LA)
  - step 4 = 010010 (HC,LA)
  - step 5 = 000110 (HC,LB)
- Period clamp: any period input below 2 is treated as 2.
- IDLE: status_o=0. When enable_i=1 and brake_i=0, on the next edge:
  - cur_period = max(clamped start, clamped target); locked_o = (cur_period == target).
  - step_o = 0; enter DEAD.
- DEAD: status_o=0 for exactly DEAD_CYCLES cycles, then enter DRIVE.
- DRIVE:
  - status_o = pattern[step_o] for exactly cur_period cycles; step_pulse_o=1 on the final cycle.
  - Next edge: enter DEAD. step_o advances mod 6 per dir_i (5+1 -> 0, 0-1 -> 5).
  - Ramp update, computed at CNT_W+1 bits (no overflow): new = (cur_period > target + ramp_step_i) ? cur_period - ramp_step_i : target.
  - locked_o = (new == target).
- Target changes: period_i is sampled only at step boundaries.
  - A slower target (larger value) takes effect immediately at the next boundary; no upward ramp.
  - ramp_step_i = 0 while cur_period > target means cur_period never changes and locked_o stays 0.
- Step period: one full step = cur_period + DEAD_CYCLES cycles. The first drive pattern appears DEAD_CYCLES+1 cycles after enable is sampled.
- enable_i falling in DEAD or DRIVE: next edge goes to IDLE with status_o=0, step_o=0, running_o=0, locked_o=0, step_pulse_o=0. The abort is immediate; no dead phase is needed because all-off is safe.
- brake_i=1 in any state:
  - Next edge: enter BDEAD with status_o=0 for DEAD_CYCLES cycles, then BRAKE with status_o=010101 (all low sides on).
  - running_o=0 in BRAKE; locked_o=0.
  - On brake_i falling in BDEAD or BRAKE: next edge goes to IDLE with status_o=0.
  - brake_i and enable_i both rising in the same cycle: brake wins.
- Never allowed: HA&LA, HB&LB or HC&LC high simultaneously. status_o changes only through an all-zero cycle, except the BRAKE -> IDLE and IDLE entries.
- All outputs are registered.

Test Plan:
- Reset mid-DRIVE: assert rst_ni=0 asynchronously -> all outputs 0 in the same cycle, FSM in IDLE.
- DEAD_CYCLES=4, start=period=10, ramp=0, dir=1, enable rises -> 4 cycles status_o=0, then 10 cycles 100100; step_pulse_o on cycle 10; next pattern 100001 after 4 zero cycles. step_o runs 0,1,2,3,4,5,0. locked_o=1 throughout.
- Ramp: start=20, period=10, ramp=3 -> drive lengths 20,17,14,11,10,10; locked_o rises with the 10-cycle step.
- Reverse and target change: dir=0 from step 0 -> step 5 (000110), then 4. Raise period_i from 10 to 30 mid-step -> the following step lasts 30 cycles, locked_o stays 1.
- Brake: brake_i=1 during step 2 -> 4 zero cycles, then 010101 held; brake_i=0 -> status_o=0, IDLE. Brake+enable rising together -> brake path taken.
- Clamp and abort: period=0, start=0 -> drive length 2. enable_i low mid-DRIVE -> next cycle status_o=0, step_o=0, running_o=0. Shoot-through checker active in every test.

Source files
------------

// File: rtl/commutation_seq.sv
// Six-step commutation sequencer: dead-time between steps, open-loop period ramp, low-side brake.
// Latency: every output is registered; the first drive pattern appears DEAD_CYCLES+1 cycles after enable_i rises.
// Backpressure: none; level-controlled free-running block with no handshake to stall it.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   enable_i / brake_i             run and brake requests (brake has priority)
//   dir_i                          1 = forward step+1, 0 = reverse step-1 (used only at step advance)
//   start_period_i, period_i       initial and target drive-phase length in clk cycles (values <2 act as 2)
//   ramp_step_i                    period decrement applied at each step boundary while ramping
//   status_o                       switch enables {HA,LA,HB,LB,HC,LC}
//   step_o, step_pulse_o           current step 0..5, strobe on the last drive cycle of a step
//   running_o, locked_o            sequencer active, current period has reached the target
module commutation_seq #(
   parameter int CNT_W       = 16,
   parameter int DEAD_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             brake_i,
   input  logic             dir_i,
   input  logic [CNT_W-1:0] start_period_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] ramp_step_i,
   output logic [5:0]       status_o,
   output logic [2:0]       step_o,
   output logic             step_pulse_o,
   output logic             running_o,
   output logic             locked_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEAD,
      S_DRIVE,
      S_BDEAD,
      S_BRAKE
   } state_t;

   localparam logic [5:0]       BRAKE_PAT  = 6'b010101;
   localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

   function automatic logic [5:0] step_pattern(input logic [2:0] s);
      case (s)
         3'd0:    step_pattern = 6'b100100;
         3'd1:    step_pattern = 6'b100001;
         3'd2:    step_pattern = 6'b001001;
         3'd3:    step_pattern = 6'b011000;
         3'd4:    step_pattern = 6'b010010;
         3'd5:    step_pattern = 6'b000110;
         default: step_pattern = 6'b000000;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
      clamp_period = (p < MIN_PERIOD) ? MIN_PERIOD : p;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_period_q, cur_period_d;
   logic [2:0]       step_q, step_d;
   logic [5:0]       status_q, status_d;
   logic             step_pulse_q, step_pulse_d;
   logic             running_q, running_d;
   logic             locked_q, locked_d;

   logic [CNT_W-1:0] tgt_period;
   logic [CNT_W-1:0] start_period;
   logic [CNT_W:0]   ramp_limit;
   logic [CNT_W-1:0] ramped_period;
   logic [2:0]       step_next;
   logic             go_idle;

   always_comb begin
      tgt_period   = clamp_period(period_i);
      start_period = clamp_period(start_period_i);
      // One extra bit so target + ramp never wraps.
      ramp_limit    = {1'b0, tgt_period} + {1'b0, ramp_step_i};
      ramped_period = ({1'b0, cur_period_q} > ramp_limit) ? (cur_period_q - ramp_step_i) : tgt_period;
      if (dir_i) begin
         step_next = (step_q == 3'd5) ? 3'd0 : (step_q + 3'd1);
      end else begin
         step_next = (step_q == 3'd0) ? 3'd5 : (step_q - 3'd1);
      end

      state_d      = state_q;
      cnt_d        = cnt_q;
      cur_period_d = cur_period_q;
      step_d       = step_q;
      status_d     = status_q;
      step_pulse_d = 1'b0;
      running_d    = running_q;
      locked_d     = locked_q;
      go_idle      = 1'b0;

      if (brake_i) begin
         case (state_q)
            S_BDEAD: begin
               if (cnt_q == '0) begin
                  state_d   = S_BRAKE;
                  status_d  = BRAKE_PAT;
                  running_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_BRAKE: begin
               status_d = BRAKE_PAT;
            end
            default: begin
               // Every entry into brake passes through an all-off window first.
               state_d   = S_BDEAD;
               cnt_d     = DEAD_LOAD;
               status_d  = '0;
               running_d = 1'b1;
               locked_d  = 1'b0;
            end
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable_i) begin
                  state_d      = S_DEAD;
                  cnt_d        = DEAD_LOAD;
                  step_d       = 3'd0;
                  cur_period_d = (start_period > tgt_period) ? start_period : tgt_period;
                  locked_d     = (start_period <= tgt_period);
                  running_d    = 1'b1;
                  status_d     = '0;
               end
            end
            S_DEAD: begin
               if (!enable_i) begin
                  go_idle = 1'b1;
               end else if (cnt_q == '0) begin
                  state_d  = S_DRIVE;
                  cnt_d    = cur_period_q - 1'b1;
                  status_d = step_pattern(step_q);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_DRIVE: begin
               if (!enable_i) begin
                  go_idle = 1'b1;
               end else if (cnt_q == '0) begin
                  // Step boundary: the only place dir_i and period_i are used.
                  state_d      = S_DEAD;
                  cnt_d        = DEAD_LOAD;
                  status_d     = '0;
                  step_d       = step_next;
                  cur_period_d = ramped_period;
                  locked_d     = (ramped_period == tgt_period);
               end else begin
                  cnt_d        = cnt_q - 1'b1;
                  // Period is at least 2, so this never fires on the first drive cycle.
                  step_pulse_d = (cnt_q == CNT_W'(1));
               end
            end
            default: begin
               go_idle = 1'b1;
            end
         endcase
      end

      if (go_idle) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         step_d    = 3'd0;
         status_d  = '0;
         running_d = 1'b0;
         locked_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         cur_period_q <= '0;
         step_q       <= 3'd0;
         status_q     <= '0;
         step_pulse_q <= 1'b0;
         running_q    <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_period_q <= cur_period_d;
         step_q       <= step_d;
         status_q     <= status_d;
         step_pulse_q <= step_pulse_d;
         running_q    <= running_d;
         locked_q     <= locked_d;
      end
   end

   assign status_o     = status_q;
   assign step_o       = step_q;
   assign step_pulse_o = step_pulse_q;
   assign running_o    = running_q;
   assign locked_o     = locked_q;

endmodule

// File: tb/tb_commutation_seq.sv
// Self-checking bench for commutation_seq: vector table, directed multi-cycle sequences, random run vs reference model.
// Latency: outputs sampled on the falling edge, half a cycle after the rising edge that produced them.
// Backpressure: none; inputs driven freely from the stimulus process.
`timescale 1ns/1ps
module tb_commutation_seq;
   localparam int CNT_W = 16;
   localparam int DEAD  = 4;

   localparam int M_OFF   = 0;
   localparam int M_GAP   = 1;
   localparam int M_ON    = 2;
   localparam int M_BGAP  = 3;
   localparam int M_BHOLD = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable, brake, dir;
   logic [CNT_W-1:0] start_p, period, ramp;
   logic [5:0]       status;
   logic [2:0]       step;
   logic             pulse, running, locked;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   commutation_seq #(.CNT_W(CNT_W), .DEAD_CYCLES(DEAD)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .enable_i       (enable),
      .brake_i        (brake),
      .dir_i          (dir),
      .start_period_i (start_p),
      .period_i       (period),
      .ramp_step_i    (ramp),
      .status_o       (status),
      .step_o         (step),
      .step_pulse_o   (pulse),
      .running_o      (running),
      .locked_o       (locked)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Safety checks on every cycle: no phase leg shorted, patterns only change through all-off.
   logic [5:0] prev_status = 6'b0;
   bit         chk_on      = 1'b0;
   always @(negedge clk) begin
      if (chk_on) begin
         chk("no_shoot_through", 32'((status[5] & status[4]) | (status[3] & status[2]) | (status[1] & status[0])), 0);
         chk("zero_between_patterns", 32'(prev_status != 6'b0 && status != 6'b0 && status != prev_status), 0);
      end
      prev_status = status;
   end

   // ---------------- reference model ----------------
   int m_mode, m_age, m_step, m_per, m_tgt;

   function automatic int clampi(input int p);
      return (p < 2) ? 2 : p;
   endfunction

   // High side rotates A,A,B,B,C,C; low side B,C,C,A,A,B. Phase p high = bit 5-2p, low = bit 4-2p.
   function automatic logic [5:0] model_pat(input int s);
      int hi, lo;
      logic [5:0] r;
      hi = s / 2;
      lo = ((s + 3) / 2) % 3;
      r = 6'b0;
      r[5 - 2*hi] = 1'b1;
      r[4 - 2*lo] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_mode = M_OFF; m_age = 0; m_step = 0; m_per = 0; m_tgt = 0;
   endtask

   task automatic model_edge(input logic en, input logic br, input logic dr, input int sp, input int pp, input int rs);
      int tgt;
      tgt = clampi(pp);
      if (br) begin
         if (m_mode == M_BGAP) begin
            if (m_age == DEAD - 1) m_mode = M_BHOLD;
            else m_age++;
         end else if (m_mode != M_BHOLD) begin
            m_mode = M_BGAP; m_age = 0;
         end
      end else if (m_mode == M_BGAP || m_mode == M_BHOLD || (m_mode != M_OFF && !en)) begin
         m_mode = M_OFF; m_step = 0;
      end else if (m_mode == M_OFF) begin
         if (en) begin
            m_mode = M_GAP; m_age = 0; m_step = 0;
            m_per = (clampi(sp) > tgt) ? clampi(sp) : tgt;
            m_tgt = tgt;
         end
      end else if (m_mode == M_GAP) begin
         if (m_age == DEAD - 1) begin m_mode = M_ON; m_age = 0; end
         else m_age++;
      end else begin
         if (m_age == m_per - 1) begin
            m_mode = M_GAP; m_age = 0;
            m_step = (m_step + (dr ? 1 : 5)) % 6;
            m_per  = (m_per > tgt + rs) ? m_per - rs : tgt;
            m_tgt  = tgt;
         end else m_age++;
      end
   endtask

   task automatic model_compare();
      logic [5:0] e_st;
      e_st = (m_mode == M_ON) ? model_pat(m_step) : (m_mode == M_BHOLD) ? 6'b010101 : 6'b0;
      chk("rand_status", 32'(status), 32'(e_st));
      chk("rand_step", 32'(step), m_step);
      chk("rand_pulse", 32'(pulse), 32'(m_mode == M_ON && m_age == m_per - 1));
      chk("rand_running", 32'(running), 32'(m_mode == M_GAP || m_mode == M_ON || m_mode == M_BGAP));
      chk("rand_locked", 32'(locked), 32'((m_mode == M_GAP || m_mode == M_ON) && m_per == m_tgt));
   endtask

   // ---------------- directed helpers ----------------
   // Called on a falling edge while status is zero. Measures zero cycles before the next
   // drive, the drive length, and whether the strobe fires exactly on its last cycle.
   task automatic wait_drive(output int gap, output int len, output logic [5:0] pat,
                             output logic [2:0] stp, output logic lk, output logic pok);
      int pc, pl;
      gap = 0; len = 0; pat = 6'b0; stp = 3'd0; lk = 1'b0; pok = 1'b0; pc = 0; pl = 0;
      while (status == 6'b0 && gap < 200) begin
         @(negedge clk);
         gap++;
      end
      chk("drive_start_seen", 32'(status != 6'b0), 1);
      pat = status; stp = step; lk = locked;
      while (status == pat && pat != 6'b0 && len < 1000) begin
         len++;
         if (pulse) begin pc++; pl = len; end
         @(negedge clk);
      end
      pok = (pc == 1 && pl == len);
   endtask

   task automatic wait_nonzero(input string name);
      int n;
      n = 0;
      while (status == 6'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(status != 6'b0), 1);
   endtask

   typedef struct {
      logic       en;
      logic       br;
      logic [5:0] st;
      logic [2:0] sp;
      logic       pu;
      logic       ru;
      logic       lk;
   } vec_t;

   vec_t       tbl [21];
   logic [5:0] pat_tbl [6];

   task automatic set_row(input int i, input logic en, input logic br, input logic [5:0] st,
                          input logic [2:0] sp, input logic pu, input logic ru, input logic lk);
      tbl[i].en = en; tbl[i].br = br; tbl[i].st = st; tbl[i].sp = sp;
      tbl[i].pu = pu; tbl[i].ru = ru; tbl[i].lk = lk;
   endtask

   int         gap, len;
   logic [5:0] pat;
   logic [2:0] stp;
   logic       lk, pok;
   int         ramp_len [6] = '{20, 17, 14, 11, 10, 10};
   logic       ramp_lk  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      pat_tbl[0] = 6'b100100; pat_tbl[1] = 6'b100001; pat_tbl[2] = 6'b001001;
      pat_tbl[3] = 6'b011000; pat_tbl[4] = 6'b010010; pat_tbl[5] = 6'b000110;

      // Clamped period 2, ramp 0, forward: enable, two steps, abort, brake+enable together, release.
      set_row(0,  0, 0, 6'b000000, 0, 0, 0, 0);
      set_row(1,  1, 0, 6'b000000, 0, 0, 1, 1);
      set_row(2,  1, 0, 6'b000000, 0, 0, 1, 1);
      set_row(3,  1, 0, 6'b000000, 0, 0, 1, 1);
      set_row(4,  1, 0, 6'b000000, 0, 0, 1, 1);
      set_row(5,  1, 0, 6'b100100, 0, 0, 1, 1);
      set_row(6,  1, 0, 6'b100100, 0, 1, 1, 1);
      set_row(7,  1, 0, 6'b000000, 1, 0, 1, 1);
      set_row(8,  1, 0, 6'b000000, 1, 0, 1, 1);
      set_row(9,  1, 0, 6'b000000, 1, 0, 1, 1);
      set_row(10, 1, 0, 6'b000000, 1, 0, 1, 1);
      set_row(11, 1, 0, 6'b100001, 1, 0, 1, 1);
      set_row(12, 0, 0, 6'b000000, 0, 0, 0, 0);
      set_row(13, 1, 1, 6'b000000, 0, 0, 1, 0);
      set_row(14, 1, 1, 6'b000000, 0, 0, 1, 0);
      set_row(15, 1, 1, 6'b000000, 0, 0, 1, 0);
      set_row(16, 1, 1, 6'b000000, 0, 0, 1, 0);
      set_row(17, 1, 1, 6'b010101, 0, 0, 0, 0);
      set_row(18, 0, 1, 6'b010101, 0, 0, 0, 0);
      set_row(19, 1, 0, 6'b000000, 0, 0, 0, 0);
      set_row(20, 0, 0, 6'b000000, 0, 0, 0, 0);

      rst_n = 1'b0; enable = 1'b0; brake = 1'b0; dir = 1'b1;
      start_p = '0; period = '0; ramp = '0;
      #12;
      chk("reset_status", 32'(status), 0);
      chk("reset_step", 32'(step), 0);
      chk("reset_pulse", 32'(pulse), 0);
      chk("reset_running", 32'(running), 0);
      chk("reset_locked", 32'(locked), 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);

      // Nominal run: period 10, no ramp, forward through a full revolution.
      start_p = 16'd10; period = 16'd10; ramp = '0; dir = 1'b1; enable = 1'b1;
      for (int k = 0; k < 7; k++) begin
         wait_drive(gap, len, pat, stp, lk, pok);
         chk("nom_gap", gap, (k == 0) ? DEAD + 1 : DEAD);
         chk("nom_len", len, 10);
         chk("nom_step", 32'(stp), k % 6);
         chk("nom_pattern", 32'(pat), 32'(pat_tbl[k % 6]));
         chk("nom_locked", 32'(lk), 1);
         chk("nom_pulse", 32'(pok), 1);
      end
      // Abort in the middle of a drive phase.
      wait_nonzero("abort_drive_seen");
      repeat (3) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_status", 32'(status), 0);
      chk("abort_step", 32'(step), 0);
      chk("abort_running", 32'(running), 0);
      chk("abort_locked", 32'(locked), 0);
      chk("abort_pulse", 32'(pulse), 0);
      @(negedge clk);

      // Ramp from 20 down to 10 in steps of 3.
      start_p = 16'd20; period = 16'd10; ramp = 16'd3; enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_drive(gap, len, pat, stp, lk, pok);
         chk("ramp_len", len, ramp_len[k]);
         chk("ramp_locked", 32'(lk), 32'(ramp_lk[k]));
      end
      enable = 1'b0;
      repeat (2) @(negedge clk);

      // Reverse direction, then a slower target taking effect at the next boundary.
      start_p = 16'd10; period = 16'd10; ramp = '0; dir = 1'b0; enable = 1'b1;
      wait_drive(gap, len, pat, stp, lk, pok);
      chk("rev_step0", 32'(stp), 0);
      chk("rev_pat0", 32'(pat), 32'(6'b100100));
      wait_drive(gap, len, pat, stp, lk, pok);
      chk("rev_step5", 32'(stp), 5);
      chk("rev_pat5", 32'(pat), 32'(6'b000110));
      period = 16'd30;
      wait_drive(gap, len, pat, stp, lk, pok);
      chk("rev_step4", 32'(stp), 4);
      chk("rev_len_before", len, 10);
      wait_drive(gap, len, pat, stp, lk, pok);
      chk("slow_step3", 32'(stp), 3);
      chk("slow_len", len, 30);
      chk("slow_locked", 32'(lk), 1);
      enable = 1'b0;
      repeat (2) @(negedge clk);

      // Brake during step 2.
      start_p = 16'd6; period = 16'd6; dir = 1'b1; enable = 1'b1;
      wait_drive(gap, len, pat, stp, lk, pok);
      wait_drive(gap, len, pat, stp, lk, pok);
      wait_nonzero("brake_drive_seen");
      chk("brake_at_step", 32'(step), 2);
      repeat (2) @(negedge clk);
      brake = 1'b1;
      for (int k = 0; k < DEAD; k++) begin
         @(negedge clk);
         chk("bdead_status", 32'(status), 0);
         chk("bdead_running", 32'(running), 1);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("brake_status", 32'(status), 32'(6'b010101));
         chk("brake_running", 32'(running), 0);
         chk("brake_locked", 32'(locked), 0);
      end
      brake = 1'b0; enable = 1'b0;
      @(negedge clk);
      chk("brake_release_status", 32'(status), 0);
      chk("brake_release_running", 32'(running), 0);
      chk("brake_release_step", 32'(step), 0);

      // Asynchronous reset in the middle of a drive phase.
      start_p = 16'd8; period = 16'd8; enable = 1'b1;
      wait_nonzero("reset_drive_seen");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_status", 32'(status), 0);
      chk("async_rst_step", 32'(step), 0);
      chk("async_rst_running", 32'(running), 0);
      chk("async_rst_locked", 32'(locked), 0);
      chk("async_rst_pulse", 32'(pulse), 0);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Vector table.
      start_p = '0; period = '0; ramp = '0; dir = 1'b1;
      for (int i = 0; i < 21; i++) begin
         enable = tbl[i].en;
         brake  = tbl[i].br;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_status", i), 32'(status), 32'(tbl[i].st));
         chk($sformatf("vec%0d_step", i), 32'(step), 32'(tbl[i].sp));
         chk($sformatf("vec%0d_pulse", i), 32'(pulse), 32'(tbl[i].pu));
         chk($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].ru));
         chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      end

      // Random run against the reference model.
      rst_n = 1'b0;
      model_reset();
      enable = 1'b1; brake = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         model_compare();
         if ($urandom_range(0, 99) < 2) enable = ~enable;
         if ($urandom_range(0, 199) < 3) brake = ~brake;
         dir = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) < 5) period  = 16'($urandom_range(0, 14));
         if ($urandom_range(0, 99) < 5) start_p = 16'($urandom_range(0, 30));
         if ($urandom_range(0, 99) < 5) ramp    = 16'($urandom_range(0, 4));
         @(posedge clk);
         model_edge(enable, brake, dir, int'(start_p), int'(period), int'(ramp));
         @(negedge clk);
      end
      model_compare();

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
